// File: rtl/usb_in_arbiter_pkg.sv
// Shared types and constants for the USB CDC IN arbiter.
// The TAG state is only present when USB_IN_ARB_TAG_EN is defined.
package usb_arb_pkg;

    `ifdef USB_IN_ARB_TAG_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TAG    = 2'd1,
        ST_STREAM = 2'd2
    } arb_state_e;
    `else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd2
    } arb_state_e;
    `endif

    localparam logic [7:0] TAG_BASE = 8'hA0;

endpackage

// File: rtl/usb_in_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req searching upward
// from ptr+1 (wrapping), returned one-hot along with a found flag.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            found
);

    logic [IW:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
            if (!found && req[idx[IW-1:0]]) begin
                pick[idx[IW-1:0]] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_in_arbiter.sv
// Round-robin arbiter multiplexing NREQ byte streams onto one CDC IN channel.
// Define USB_IN_ARB_TAG_EN to prefix each burst with a TAG_BASE|owner byte.
module usb_in_arbiter
    import usb_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [7:0]        usb_data_o,
    output logic              usb_valid_o,
    input  logic              usb_ready_i,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e          state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [IW-1:0]       gidx_q, gidx_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [NREQ-1:0][7:0] data_arr;
    logic [NREQ-1:0]      pick;
    logic                 found;
    logic [IW-1:0]        pick_idx;
    logic                 beat;

    assign data_arr = req_data_i;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req_valid_i),
        .ptr   (ptr_q),
        .pick  (pick),
        .found (found)
    );

    always_comb begin
        pick_idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick[j]) pick_idx = IW'(j);
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        usb_valid_o = 1'b0;
        usb_data_o  = 8'h00;
        req_ready_o = '0;
        beat        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    `ifdef USB_IN_ARB_TAG_EN
                    state_d = ST_TAG;
                    `else
                    state_d = ST_STREAM;
                    `endif
                end
            end
            `ifdef USB_IN_ARB_TAG_EN
            ST_TAG: begin
                usb_valid_o = 1'b1;
                usb_data_o  = TAG_BASE | 8'(gidx_q);
                if (usb_ready_i) state_d = ST_STREAM;
            end
            `endif
            ST_STREAM: begin
                usb_data_o          = data_arr[gidx_q];
                usb_valid_o         = req_valid_i[gidx_q];
                req_ready_o[gidx_q] = usb_ready_i;
                beat                = usb_valid_o & usb_ready_i;
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    // last and cap on the same beat collapse into one release
                    if (req_last_i[gidx_q] || cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = ST_IDLE;
                        ptr_d   = gidx_q;
                        cnt_d   = '0;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = |grant_q;

endmodule
